// File: rtl/reset_sequencer_pkg.sv
// Shared state encodings and default timing constants
// for the staged power-on / soft reset sequencer.
package reset_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_HOLD = 3'd0,
      ST_POR  = 3'd1,
      ST_REL  = 3'd2,
      ST_RUN  = 3'd3,
      ST_SOFT = 3'd4
   } state_e;

   localparam int DEF_CNT_WIDTH   = 24;
   localparam int DEF_POR_CYCLES  = 32769;
   localparam int DEF_NUM_STAGES  = 4;
   localparam int DEF_STAGE_GAP   = 16;
   localparam int DEF_SOFT_CYCLES = 64;
   localparam int MAX_STAGES      = 8;

   function automatic bit fits_cnt(int value, int width);
      if (width >= 31) begin
         return 1'b1;
      end
      return value < (1 << width);
   endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchroniser with asynchronous reset to a
// selectable value; also serves as a reset-deassert synchroniser.
module reset_sequencer_sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_d;
   logic meta_q;
   logic sync_d;
   logic sync_q;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: waits for PLL lock plus a power-on
// delay, then releases the reset outputs one by one.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int POR_CYCLES  = DEF_POR_CYCLES,
   parameter int NUM_STAGES  = DEF_NUM_STAGES,
   parameter int STAGE_GAP   = DEF_STAGE_GAP,
   parameter int SOFT_CYCLES = DEF_SOFT_CYCLES
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  pll_locked,
   input  logic                  soft_reset_req,
   output logic [NUM_STAGES-1:0] reset_out,
   output logic                  busy,
   output logic                  ready
);

   if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
      $error("reset_sequencer: NUM_STAGES must be 1..8");
   end
   if (POR_CYCLES < 1 || !fits_cnt(POR_CYCLES, CNT_WIDTH)) begin : g_bad_por
      $error("reset_sequencer: POR_CYCLES does not fit the counter");
   end
   if (STAGE_GAP < 1 || !fits_cnt(STAGE_GAP, CNT_WIDTH)) begin : g_bad_gap
      $error("reset_sequencer: STAGE_GAP does not fit the counter");
   end
   if (SOFT_CYCLES < 1 || !fits_cnt(SOFT_CYCLES, CNT_WIDTH)) begin : g_bad_soft
      $error("reset_sequencer: SOFT_CYCLES does not fit the counter");
   end

   localparam logic [CNT_WIDTH-1:0] POR_LAST  = CNT_WIDTH'(POR_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(STAGE_GAP - 1);
   localparam logic [CNT_WIDTH-1:0] SOFT_LAST = CNT_WIDTH'(SOFT_CYCLES - 1);

   logic rst_int_n;
   logic lock_s;

   reset_sequencer_sync_2ff #(
      .RST_VAL(1'b0)
   ) u_rst_sync (
      .clk  (clock),
      .rst_n(reset_n),
      .d    (1'b1),
      .q    (rst_int_n)
   );

   // Lock is only trusted once the internal reset has been released.
   reset_sequencer_sync_2ff #(
      .RST_VAL(1'b0)
   ) u_lock_sync (
      .clk  (clock),
      .rst_n(rst_int_n),
      .d    (pll_locked),
      .q    (lock_s)
   );

   state_e                  state_d;
   state_e                  state_q;
   logic [CNT_WIDTH-1:0]    cnt_d;
   logic [CNT_WIDTH-1:0]    cnt_q;
   logic [CNT_WIDTH-1:0]    cnt_inc;
   logic [NUM_STAGES-1:0]   reset_out_d;
   logic [NUM_STAGES-1:0]   reset_out_q;
   logic [NUM_STAGES-1:0]   rel_next;
   logic                    busy_d;
   logic                    busy_q;
   logic                    ready_d;
   logic                    ready_q;
   logic                    por_done;
   logic                    gap_done;
   logic                    soft_done;
   logic                    last_stage;

   assign por_done   = (cnt_q == POR_LAST);
   assign gap_done   = (cnt_q == GAP_LAST);
   assign soft_done  = (cnt_q == SOFT_LAST);
   assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
   // Releasing stages low-to-high is a shift toward the MSB.
   assign rel_next   = reset_out_q << 1;
   assign last_stage = (rel_next == '0);

   always_comb begin
      state_d = state_q;
      if (!lock_s) begin
         state_d = ST_HOLD;
      end else begin
         unique case (state_q)
            ST_HOLD: state_d = ST_POR;
            ST_POR: begin
               if (por_done) begin
                  state_d = ST_REL;
               end
            end
            ST_REL: begin
               if (gap_done && last_stage) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (soft_reset_req) begin
                  state_d = ST_SOFT;
               end
            end
            ST_SOFT: begin
               if (soft_done) begin
                  state_d = ST_REL;
               end
            end
            default: state_d = ST_HOLD;
         endcase
      end
   end

   always_comb begin
      cnt_d       = '0;
      reset_out_d = reset_out_q;
      unique case (state_q)
         ST_POR, ST_SOFT: cnt_d = cnt_inc;
         ST_REL: begin
            if (gap_done) begin
               reset_out_d = rel_next;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_RUN:  reset_out_d = '0;
         default: reset_out_d = '1;
      endcase
      if (state_d != state_q) begin
         cnt_d = '0;
      end
      if (state_d == ST_HOLD || state_d == ST_SOFT) begin
         reset_out_d = '1;
      end
      busy_d  = |reset_out_d;
      // Rises one clock after RUN entry, falls on the exit edge.
      ready_d = (state_q == ST_RUN) && (state_d == ST_RUN);
   end

   always_ff @(posedge clock or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q     <= ST_HOLD;
         cnt_q       <= '0;
         reset_out_q <= '1;
         busy_q      <= 1'b1;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         reset_out_q <= reset_out_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
      end
   end

   assign reset_out = reset_out_q;
   assign busy      = busy_q;
   assign ready     = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: expected output changes are queued as stimulus
// is issued and a monitor compares every change the DUT makes.
module tb_reset_sequencer;

   localparam int CW  = 8;
   localparam int P   = 40;
   localparam int N   = 4;
   localparam int G   = 5;
   localparam int S   = 9;
   localparam int INF = 32'h7fff_ffff;

   logic         clock = 1'b0;
   logic         reset_n = 1'b1;
   logic         pll_locked = 1'b0;
   logic         soft_reset_req = 1'b0;
   logic [N-1:0] reset_out;
   logic         busy;
   logic         ready;
   logic [0:0]   reset_out1;
   logic         busy1;
   logic         ready1;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   int run_from = INF;
   int rel_min = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int           cyc;
      logic [N-1:0] ro;
      logic         rd;
   } ev_t;

   ev_t exp_q[$];
   ev_t hist[$];

   reset_sequencer #(
      .CNT_WIDTH(CW), .POR_CYCLES(P), .NUM_STAGES(N),
      .STAGE_GAP(G), .SOFT_CYCLES(S)
   ) dut (
      .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked),
      .soft_reset_req(soft_reset_req), .reset_out(reset_out),
      .busy(busy), .ready(ready)
   );

   reset_sequencer #(
      .CNT_WIDTH(CW), .POR_CYCLES(P), .NUM_STAGES(1),
      .STAGE_GAP(1), .SOFT_CYCLES(S)
   ) dut1 (
      .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked),
      .soft_reset_req(soft_reset_req), .reset_out(reset_out1),
      .busy(busy1), .ready(ready1)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  name, got, want, cyc);
      end
   endtask

   // Records an output change only if it differs from the model's
   // current value after all previously planned changes.
   function automatic void expect_out(int c, logic [N-1:0] ro, logic rd);
      logic [N-1:0] pro;
      logic         prd;
      ev_t          e;
      pro = '1;
      prd = 1'b0;
      if (hist.size() > 0) begin
         pro = hist[$].ro;
         prd = hist[$].rd;
      end
      if (ro == pro && rd == prd) return;
      e.cyc = c;
      e.ro  = ro;
      e.rd  = rd;
      exp_q.push_back(e);
      hist.push_back(e);
   endfunction

   function automatic void cut(int c);
      while (exp_q.size() > 0 && exp_q[$].cyc >= c) void'(exp_q.pop_back());
      while (hist.size() > 0 && hist[$].cyc >= c) void'(hist.pop_back());
   endfunction

   // Stage i drops i+1 gaps after release starts; ready follows a clock later.
   function automatic void plan_release(int rel);
      logic [N-1:0] m;
      for (int i = 0; i < N; i++) begin
         m = '1;
         m = m << (i + 1);
         expect_out(rel + G * (i + 1), m, 1'b0);
      end
      expect_out(rel + G * N + 1, '0, 1'b1);
      run_from = rel + G * N + 1;
   endfunction

   function automatic int max2(int a, int b);
      return (a > b) ? a : b;
   endfunction

   task automatic wait_to(int c);
      while (cyc < c) @(negedge clock);
   endtask

   task automatic wait_rand(int lo, int hi);
      repeat ($urandom_range(hi, lo)) @(negedge clock);
   endtask

   task automatic soft_now(output int s);
      s = cyc + 1;
      soft_reset_req = 1'b1;
      if (s >= run_from) begin
         cut(s);
         expect_out(s, '1, 1'b0);
         plan_release(s + S);
      end
      @(negedge clock);
      soft_reset_req = 1'b0;
   endtask

   task automatic lock_drop_now(output int a);
      a = cyc;
      pll_locked = 1'b0;
      cut(a + 3);
      expect_out(a + 3, '1, 1'b0);
      run_from = INF;
   endtask

   task automatic lock_rise_now();
      pll_locked = 1'b1;
      plan_release(max2(cyc + 3, rel_min) + P);
   endtask

   task automatic reset_assert_now();
      int a;
      a = cyc;
      reset_n = 1'b0;
      cut(a + 1);
      expect_out(a + 1, '1, 1'b0);
      run_from = INF;
      #1;
      check("async_reset_out", 32'(reset_out), 32'hF);
      check("async_busy", 32'(busy), 32'h1);
      check("async_ready", 32'(ready), 32'h0);
      check("async_reset_out1", 32'(reset_out1), 32'h1);
      @(negedge clock);
   endtask

   task automatic reset_release_now();
      reset_n = 1'b1;
      rel_min = cyc + 5;
      if (pll_locked) plan_release(rel_min + P);
   endtask

   task automatic drain(string name);
      if (hist.size() > 0) wait_to(hist[$].cyc + 3);
      check(name, 32'(exp_q.size()), 32'h0);
   endtask

   initial begin : monitor
      logic [N-1:0] pro;
      logic         pb;
      logic         pr;
      ev_t          e;
      wait (mon_en);
      pro = reset_out;
      pb  = busy;
      pr  = ready;
      forever begin
         @(posedge clock);
         #1;
         if ({reset_out, busy, ready} !== {pro, pb, pr}) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_change: cycle %0d ro=%b busy=%b ready=%b",
                        cyc, reset_out, busy, ready);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || e.ro !== reset_out ||
                   busy !== (|e.ro) || ready !== e.rd) begin
                  miscompares++;
                  $display("FAIL output_event: got cycle %0d ro=%b busy=%b ready=%b, expected cycle %0d ro=%b busy=%b ready=%b",
                           cyc, reset_out, busy, ready,
                           e.cyc, e.ro, |e.ro, e.rd);
               end
            end
         end
         pro = reset_out;
         pb  = busy;
         pr  = ready;
      end
   end

   initial begin : stim
      int s;
      int a;
      int rel;
      #1;
      reset_n    = 1'b0;
      pll_locked = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_out", 32'(reset_out), 32'hF);
      check("reset_busy", 32'(busy), 32'h1);
      check("reset_ready", 32'(ready), 32'h0);
      check("reset_out1", 32'(reset_out1), 32'h1);
      mon_en = 1'b1;
      @(negedge clock);

      // Power-up with lock already present; single-stage build alongside.
      reset_release_now();
      rel = rel_min + P;
      wait_to(rel);
      check("single_held", 32'(reset_out1), 32'h1);
      wait_to(rel + 1);
      check("single_drop", 32'(reset_out1), 32'h0);
      check("single_ready_lag", 32'(ready1), 32'h0);
      wait_to(rel + 2);
      check("single_ready", 32'(ready1), 32'h1);
      drain("powerup_drain");

      // Soft resets, with extra requests during SOFT/REL that must be ignored.
      repeat (4) begin
         wait_rand(1, 8);
         soft_now(s);
         wait_rand(1, S + G * N - 6);
         soft_now(a);
         wait_rand(1, 4);
         drain("soft_drain");
      end

      // Lock loss after stage 1 has been released, then relock.
      wait_rand(1, 5);
      soft_now(s);
      wait_to(s + S + 2 * G - 2 + $urandom_range(G - 2, 0));
      lock_drop_now(a);
      wait_rand(4, 20);
      lock_rise_now();
      drain("lockloss_drain");

      // Lock loss coinciding with a soft request: lock loss wins.
      lock_drop_now(a);
      wait_to(a + 2);
      soft_now(s);
      wait_rand(2, 6);
      lock_rise_now();
      drain("lock_vs_soft_drain");

      // Random mix of soft requests and lock glitches at any phase.
      repeat (25) begin
         case ($urandom_range(3, 0))
            0, 1: soft_now(s);
            2: begin
               lock_drop_now(a);
               wait_rand(4, 15);
               lock_rise_now();
            end
            default: ;
         endcase
         wait_rand(1, 40);
      end
      drain("random_drain");

      // Late lock: reset released while the PLL is still unlocked.
      reset_assert_now();
      pll_locked = 1'b0;
      wait_rand(2, 4);
      reset_release_now();
      repeat (1000) @(negedge clock);
      check("late_lock_out", 32'(reset_out), 32'hF);
      check("late_lock_ready", 32'(ready), 32'h0);
      lock_rise_now();
      drain("late_lock_drain");

      // Async reset midway through the power-on delay restarts it.
      reset_assert_now();
      wait_rand(2, 4);
      reset_release_now();
      wait_to(rel_min + P / 2);
      reset_assert_now();
      wait_rand(2, 4);
      reset_release_now();
      drain("por_restart_drain");

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
